axilite_regfile: RTL and testbench
==================================

Name: axilite_regfile

Overview:
- AXI4-Lite responder (slave endpoint) terminating an AXI4-Lite bus in a bank of NUM_REGS 32-bit read/write registers.
- Sits at the far end of an interconnect or externally exported AXI4-Lite port, and exposes the register contents as flat fabric outputs with per-register write strobes.
- Supports one outstanding write and one outstanding read. The read and write paths are independent.

Parameters:
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 32, byte address width.
- NUM_REGS, 16, number of 32-bit registers; range 1..256.
- RESET_VALUE, 32'h0, reset value of every register.
- ID_VALUE, 32'h0, value returned by register 0 when AXIL_ID_REG_EN is defined.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  C_AXI_ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read valid
- s_axi_rready  in  1  read ready
- reg_out  out  32*NUM_REGS  register contents; register i is at bits [32*i+31:32*i]
- wr_stb  out  NUM_REGS  one-cycle pulse for each register that was written

Behaviour:
- Clocking and reset:
  - Single clock aclk.
  - Reset is asynchronous and active-low on aresetn. All state clears immediately on assertion.
- Reset values:
  - awready, wready, arready, bvalid, rvalid, wr_stb = 0.
  - bresp, rresp, rdata = 0.
  - Every register = RESET_VALUE.
  - awready, wready and arready go to 1 on the first clock edge after aresetn deasserts.
- Decode:
  - idx = addr[C_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - idx >= NUM_REGS is an error and returns SLVERR (2'b10). Otherwise the response is OKAY (2'b00).
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready is 1 until an AW handshake occurs, then 0, and the address is latched. wready is 1 until a W handshake occurs, then 0, and data and strobes are latched.
  - AW and W are accepted in either order or in the same cycle.
  - On the edge where the second of the two is held (or both arrive together):
    - For a valid idx, each byte b with wstrb[b]=1 is updated.
    - wr_stb[idx] pulses for exactly one cycle. It pulses even when wstrb=0.
    - bresp is set.
    - bvalid=1; the FSM moves to W_RESP.
  - Same-cycle AW+W in W_IDLE gives bvalid on the next cycle, and reg_out shows the new value in that same cycle.
  - W_RESP: bvalid and bresp are held until bready. On the bready edge: bvalid=0, awready=wready=1, return to W_IDLE.
  - An error write changes no register and produces no wr_stb.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On an AR handshake, rdata and rresp are registered, rvalid=1, arready=0, and the FSM moves to R_DATA. Latency is 1 cycle from AR handshake to rvalid.
  - rdata=0 on an error read.
  - R_DATA: rdata, rresp and rvalid are held stable until rready. On the rready edge: rvalid=0, arready=1, return to R_IDLE.
  - Throughput is at most one transaction per 2 cycles on each channel.
- Simultaneous read and write to the same register: the read returns the pre-write value, because it samples on the same edge as the update.
- Backpressure: bvalid or rvalid may be held indefinitely with no data loss. The opposite path continues to operate.
- Reset mid-transaction: outstanding transactions are dropped. No response is issued after reset.
- VALID/READY on the s_axi ports follow AXI4-Lite protocol rules. Outputs never depend combinationally on inputs.

Optional Feature:
- Macro: AXIL_ID_REG_EN.
- Defined:
  - Register 0 is read-only and always reads ID_VALUE. reg_out[31:0] = ID_VALUE.
  - A write to idx 0 returns SLVERR, does not change the register, and does not pulse wr_stb[0].
- Undefined: register 0 is an ordinary read/write register.

Test Plan:
- Reset release, then write 0x8 with data 0xDEADBEEF, wstrb=4'hF, AW and W in the same cycle -> bvalid next cycle with bresp=00; wr_stb[2] pulses once; reg_out[95:64]=0xDEADBEEF.
- W presented 3 cycles before AW, data 0x11223344, wstrb=4'b0101 to reg 2 (previously 0xDEADBEEF) -> wready drops after the W handshake; reg 2 becomes 0xDE22BE44 only after AW; bresp=00.
- Read 0x8 with rready held low for 5 cycles -> rvalid=1 one cycle after the AR handshake; rdata=0xDE22BE44 held stable; arready=0 until rready.
- Read and write of 0x4 to 0x5555AAAA in the same cycle, reg 1 previously 0 -> rdata=0x00000000, then a subsequent read returns 0x5555AAAA.
- Write and read at address 4*NUM_REGS (0x40 with NUM_REGS=16) -> bresp=10, rresp=10, rdata=0, no wr_stb, all registers unchanged.
- With AXIL_ID_REG_EN and ID_VALUE=0x50554F45, write 0x0 -> bresp=10 and register 0 unchanged; read 0x0 -> rdata=0x50554F45. aresetn asserted while bvalid=1 -> bvalid=0 immediately.

Source files
------------

// File: rtl/axilite_regfile.sv
// axilite_regfile: AXI4-Lite responder backed by NUM_REGS 32-bit read/write registers.
// Register contents are exported flat on reg_out, and each write pulses wr_stb for one cycle.
// Independent write (WIdle/WResp) and read (RIdle/RData) FSMs, one transaction outstanding each.
// Optional macro AXIL_ID_REG_EN: register 0 becomes read-only and always reads ID_VALUE.
module axilite_regfile #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS         = 16,
  parameter logic [31:0] RESET_VALUE      = 32'h0,
  parameter logic [31:0] ID_VALUE         = 32'h0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  output logic [C_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  wr_stb
);

  localparam int unsigned DW = C_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = C_AXI_ADDR_WIDTH - 2;
  localparam logic [IW-1:0] NumRegsIdx = IW'(NUM_REGS);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [0:0] {WIdle, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic          awready_q, awready_d, wready_q, wready_d;
  logic          aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          aw_hs, w_hs, b_hs, wr_commit, wr_err;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          ar_hs, r_hs, rd_err;
  logic [IW-1:0] ar_idx;
  logic [DW-1:0] rd_val;

  // Write handshakes; a channel accepted this cycle bypasses its holding register.
  always_comb begin
    aw_hs     = s_axi_awvalid & awready_q;
    w_hs      = s_axi_wvalid & wready_q;
    b_hs      = bvalid_q & s_axi_bready;
    wr_idx    = aw_hs ? s_axi_awaddr[C_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
    wr_data   = w_hs ? s_axi_wdata : wdata_q;
    wr_strb   = w_hs ? s_axi_wstrb : wstrb_q;
    wr_commit = (w_state_q == WIdle) & (aw_hs | aw_have_q) & (w_hs | w_have_q);
    wr_err    = (wr_idx >= NumRegsIdx);
`ifdef AXIL_ID_REG_EN
    wr_err    = wr_err | (wr_idx == '0);
`endif
  end

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (wr_commit) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM outputs: channel readiness, holding registers and the B response.
  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_idx_d  = wr_idx;
    wdata_d   = wr_data;
    wstrb_d   = wr_strb;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        if (wr_commit) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err ? RespSlvErr : RespOkay;
        end else begin
          aw_have_d = aw_have_q | aw_hs;
          w_have_d  = w_have_q | w_hs;
          awready_d = ~(aw_have_q | aw_hs);
          wready_d  = ~(w_have_q | w_hs);
        end
      end
      WResp: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Register bank update with byte strobes; strobe pulses even when no byte is enabled.
  always_comb begin
    regs_d   = regs_q;
    wr_stb_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_commit && !wr_err && (wr_idx == IW'(i))) begin
        wr_stb_d[i] = 1'b1;
        for (int unsigned b = 0; b < SW; b++) begin
          if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state_q <= WIdle;
    else          w_state_q <= w_state_d;
  end

  // Write datapath and register bank.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      wr_stb_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= DW'(RESET_VALUE);
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_stb_q  <= wr_stb_d;
      regs_q    <= regs_d;
    end
  end

  // Read decode: samples the bank before any same-edge write lands.
  always_comb begin
    ar_hs  = s_axi_arvalid & arready_q;
    r_hs   = rvalid_q & s_axi_rready;
    ar_idx = s_axi_araddr[C_AXI_ADDR_WIDTH-1:2];
    rd_err = (ar_idx >= NumRegsIdx);
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) rd_val = regs_q[i];
    end
`ifdef AXIL_ID_REG_EN
    if (ar_idx == '0) rd_val = DW'(ID_VALUE);
`endif
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (r_hs) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Read FSM outputs; rdata/rresp hold until the next accepted address.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        arready_d = ~ar_hs;
        if (ar_hs) begin
          rvalid_d = 1'b1;
          rresp_d  = rd_err ? RespSlvErr : RespOkay;
          rdata_d  = rd_err ? '0 : rd_val;
        end
      end
      RData: begin
        if (r_hs) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state_q <= RIdle;
    else          r_state_q <= r_state_d;
  end

  // Read datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Flatten the bank onto reg_out.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[DW*i +: DW] = regs_q[i];
`ifdef AXIL_ID_REG_EN
    reg_out[DW-1:0] = DW'(ID_VALUE);
`endif
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_stb        = wr_stb_q;

  // Byte-offset address bits are ignored by design.
  logic unused_bits;
`ifdef AXIL_ID_REG_EN
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], ID_VALUE};
`endif

endmodule

// File: tb/tb_axilite_regfile.sv
// Self-checking bench for axilite_regfile: transaction-level model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with backpressure.
module tb_axilite_regfile;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned VW       = 32 * NUM_REGS;
  localparam int unsigned IW       = $clog2(NUM_REGS);
  localparam logic [31:0] ID_VALUE = 32'h5055_4F45;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic s_axi_bready = 1'b1, s_axi_rready = 1'b1;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [VW-1:0] reg_out;
  logic [NUM_REGS-1:0] wr_stb;

  axilite_regfile #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32), .NUM_REGS(NUM_REGS),
    .RESET_VALUE(32'h0), .ID_VALUE(ID_VALUE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .reg_out(reg_out),
    .wr_stb(wr_stb)
  );

  always #5 aclk = ~aclk;

  int total = 0, bad = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int stb_cnt [NUM_REGS];
  bit bp_en = 1'b0;
  logic [1:0]  last_bresp = 2'b11, last_rresp = 2'b11;
  logic [31:0] last_rdata = '0;

  // Model state: expected register contents and expected channel behaviour.
  logic [31:0] m_regs [NUM_REGS];
  logic m_awready = 0, m_wready = 0, m_arready = 0, m_bvalid = 0, m_rvalid = 0;
  logic m_aw_got = 0, m_w_got = 0;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  logic [31:0] m_rdata = 0, m_wdata = 0;
  logic [3:0]  m_wstrb = 0;
  logic [NUM_REGS-1:0] m_stb = '0;
  int unsigned m_aw_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic bit is_wr_err(input int unsigned idx);
`ifdef AXIL_ID_REG_EN
    return (idx >= NUM_REGS) || (idx == 0);
`else
    return idx >= NUM_REGS;
`endif
  endfunction

  function automatic logic [31:0] rd_val(input int unsigned idx);
    if (idx >= NUM_REGS) return 32'h0;
`ifdef AXIL_ID_REG_EN
    if (idx == 0) return ID_VALUE;
`endif
    return m_regs[IW'(idx)];
  endfunction

  function automatic logic [VW-1:0] exp_reg_out();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = m_regs[i];
`ifdef AXIL_ID_REG_EN
    v[31:0] = ID_VALUE;
`endif
    return v;
  endfunction

  function automatic int stb_total();
    int s = 0;
    for (int i = 0; i < NUM_REGS; i++) s += stb_cnt[i];
    return s;
  endfunction

  // Model: one AXI-Lite transaction at a time per direction; reads see pre-write contents.
  initial forever begin
    @(posedge aclk or negedge aresetn);
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
      {m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_aw_got, m_w_got} = '0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0; m_stb = '0;
    end else begin
      m_stb = '0;
      if (m_rvalid) begin
        if (s_axi_rready) begin m_rvalid = 0; r_cnt++; end
      end else if (s_axi_arvalid && m_arready) begin
        ar_cnt++;
        m_rvalid = 1;
        m_rresp  = ((s_axi_araddr >> 2) >= NUM_REGS) ? 2'b10 : 2'b00;
        m_rdata  = rd_val(s_axi_araddr >> 2);
      end
      m_arready = !m_rvalid;
      if (m_bvalid) begin
        if (s_axi_bready) begin m_bvalid = 0; b_cnt++; end
      end else begin
        if (s_axi_awvalid && m_awready) begin
          m_aw_got = 1; m_aw_idx = s_axi_awaddr >> 2; aw_cnt++;
        end
        if (s_axi_wvalid && m_wready) begin
          m_w_got = 1; m_wdata = s_axi_wdata; m_wstrb = s_axi_wstrb; w_cnt++;
        end
        if (m_aw_got && m_w_got) begin
          if (!is_wr_err(m_aw_idx)) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) m_regs[IW'(m_aw_idx)][8*b +: 8] = m_wdata[8*b +: 8];
            m_stb[IW'(m_aw_idx)] = 1'b1;
          end
          m_bresp  = is_wr_err(m_aw_idx) ? 2'b10 : 2'b00;
          m_bvalid = 1; m_aw_got = 0; m_w_got = 0;
        end
      end
      m_awready = !m_bvalid && !m_aw_got;
      m_wready  = !m_bvalid && !m_w_got;
    end
  end

  // Compare every output against the model once per cycle, away from the active edge.
  initial begin
    for (int i = 0; i < NUM_REGS; i++) stb_cnt[i] = 0;
    forever begin
      @(negedge aclk);
      chk("awready", 32'(s_axi_awready), 32'(m_awready));
      chk("wready", 32'(s_axi_wready), 32'(m_wready));
      chk("arready", 32'(s_axi_arready), 32'(m_arready));
      chk("bvalid", 32'(s_axi_bvalid), 32'(m_bvalid));
      chk("rvalid", 32'(s_axi_rvalid), 32'(m_rvalid));
      chk("bresp", 32'(s_axi_bresp), 32'(m_bresp));
      chk("rresp", 32'(s_axi_rresp), 32'(m_rresp));
      chk("rdata", s_axi_rdata, m_rdata);
      chk("wr_stb", 32'(wr_stb), 32'(m_stb));
      chk_vec("reg_out", reg_out, exp_reg_out());
      if (s_axi_bvalid && s_axi_bready) last_bresp = s_axi_bresp;
      if (s_axi_rvalid && s_axi_rready) begin last_rresp = s_axi_rresp; last_rdata = s_axi_rdata; end
      for (int i = 0; i < NUM_REGS; i++) if (wr_stb[i]) stb_cnt[i]++;
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  function automatic int cnt_of(input int ch);
    case (ch)
      0: return aw_cnt;
      1: return w_cnt;
      2: return ar_cnt;
      3: return b_cnt;
      default: return r_cnt;
    endcase
  endfunction

  task automatic wait_inc(input string nm, input int ch, input int n0);
    for (int k = 0; k < 200 && cnt_of(ch) == n0; k++) cyc();
    total++;
    if (cnt_of(ch) == n0) begin
      bad++;
      $display("FAIL %s_timeout: handshake count %0d, required above %0d", nm, cnt_of(ch), n0);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n0;
    repeat (dly) cyc();
    n0 = aw_cnt;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    wait_inc("aw", 0, n0);
    s_axi_awvalid = 1'b0; s_axi_awaddr = $urandom;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n0;
    repeat (dly) cyc();
    n0 = w_cnt;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    wait_inc("w", 1, n0);
    s_axi_wvalid = 1'b0; s_axi_wdata = $urandom;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    int n0 = b_cnt;
    last_bresp = 2'b11;
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    wait_inc("b", 3, n0);
  endtask

  task automatic do_read(input logic [31:0] a, input int dly);
    int n0;
    last_rresp = 2'b11; last_rdata = 32'hBAD0_BAD0;
    repeat (dly) cyc();
    n0 = r_cnt;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    wait_inc("ar", 2, ar_cnt);
    s_axi_arvalid = 1'b0; s_axi_araddr = $urandom;
    wait_inc("r", 4, n0);
  endtask

  // Random B/R backpressure while enabled.
  initial forever begin
    cyc();
    if (bp_en) begin
      s_axi_bready = ($urandom_range(0, 3) != 0);
      s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [VW-1:0] rst_vec = '0;
    int stb0;
`ifdef AXIL_ID_REG_EN
    rst_vec[31:0] = ID_VALUE;
`endif
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk_vec("rst_reg_out", reg_out, rst_vec);
    aresetn = 1'b1;
    cyc();
    chk("awready_after_release", 32'(s_axi_awready), 32'd1);

    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0);
    chk("t1_bresp", 32'(last_bresp), 32'd0);
    chk("t1_reg2", reg_out[95:64], 32'hDEAD_BEEF);
    chk("t1_stb2_count", 32'(stb_cnt[2]), 32'd1);

    do_write(32'h8, 32'h1122_3344, 4'b0101, 3, 0);
    chk("t2_bresp", 32'(last_bresp), 32'd0);
    chk("t2_reg2", reg_out[95:64], 32'hDE22_BE44);

    s_axi_rready = 1'b0;
    fork
      do_read(32'h8, 0);
      begin repeat (6) cyc(); s_axi_rready = 1'b1; end
    join
    chk("t3_rdata", last_rdata, 32'hDE22_BE44);
    chk("t3_rresp", 32'(last_rresp), 32'd0);

    fork
      do_write(32'h4, 32'h5555_AAAA, 4'hF, 0, 0);
      do_read(32'h4, 0);
    join
    chk("t4_read_old", last_rdata, 32'h0);
    do_read(32'h4, 0);
    chk("t4_read_new", last_rdata, 32'h5555_AAAA);

    stb0 = stb_total();
    do_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0);
    chk("t5_bresp", 32'(last_bresp), 32'd2);
    do_read(32'h40, 0);
    chk("t5_rresp", 32'(last_rresp), 32'd2);
    chk("t5_rdata", last_rdata, 32'h0);
    chk("t5_no_stb", 32'(stb_total()), 32'(stb0));
    chk("t5_reg2", reg_out[95:64], 32'hDE22_BE44);
    chk("t5_reg1", reg_out[63:32], 32'h5555_AAAA);

`ifdef AXIL_ID_REG_EN
    do_write(32'h0, 32'hA5A5_0F0F, 4'hF, 0, 1);
    chk("t6_bresp", 32'(last_bresp), 32'd2);
    chk("t6_reg0", reg_out[31:0], 32'h5055_4F45);
    do_read(32'h0, 0);
    chk("t6_rdata", last_rdata, 32'h5055_4F45);
`else
    do_write(32'h0, 32'hA5A5_0F0F, 4'hF, 0, 1);
    chk("t6_bresp", 32'(last_bresp), 32'd0);
    do_read(32'h0, 0);
    chk("t6_rdata", last_rdata, 32'hA5A5_0F0F);
`endif

    bp_en = 1'b1;
    fork
      for (int n = 0; n < 150; n++)
        do_write((32'($urandom_range(0, NUM_REGS + 1)) << 2) | 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int n = 0; n < 150; n++)
        do_read((32'($urandom_range(0, NUM_REGS + 1)) << 2) | 32'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    join
    bp_en = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    cyc();

    // Reset while a write response is pending.
    s_axi_bready = 1'b0;
    fork
      send_aw(32'hC, 0);
      send_w(32'hCAFE_F00D, 4'hF, 0);
    join
    for (int k = 0; k < 20 && !s_axi_bvalid; k++) cyc();
    chk("t7_bvalid_pending", 32'(s_axi_bvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("t7_bvalid_in_reset", 32'(s_axi_bvalid), 32'd0);
    chk_vec("t7_reg_out_in_reset", reg_out, rst_vec);
    repeat (2) cyc();
    aresetn = 1'b1;
    s_axi_bready = 1'b1;
    repeat (5) cyc();
    chk("t7_no_late_bvalid", 32'(s_axi_bvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
